// File: rtl/decoder_nx2n_reg.sv
// Registered N-to-2^N one-hot decoder with valid/ready load and optional auto-scan rotation.
// Scan hardware (SCAN state, prescaler, scan input) exists only when DECODER_SCAN_EN is defined.
module decoder_nx2n_reg #(
    parameter int N          = 2,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int SCAN_DIV   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [N-1:0]        a,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic                scan,
    output logic [(1<<N)-1:0]   y,
    output logic                y_valid,
    output logic [N-1:0]        idx
);
    localparam int W = 1 << N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t         r_state, w_nxt_state;
    logic [N-1:0]   r_idx, w_nxt_idx;
    logic [W-1:0]   r_y, w_nxt_y;
    logic           r_vld, w_nxt_vld;
    logic           w_ready;
    logic           w_accept;

`ifdef DECODER_SCAN_EN
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);

    logic [PW-1:0]  r_pre, w_nxt_pre;

    // A pending scan request blocks new indices so scan always wins a tie.
    assign w_ready = en & ~scan & (r_state != SCAN);
`else
    logic           w_unused_scan;

    assign w_unused_scan = scan;
    assign w_ready       = en;
`endif

    assign w_accept = a_valid & w_ready;
    assign a_ready  = w_ready;
    assign y        = r_y;
    assign y_valid  = r_vld;
    assign idx      = r_idx;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
`ifdef DECODER_SCAN_EN
        w_nxt_pre   = r_pre;
`endif
        if (!en) begin
            w_nxt_state = IDLE;
            w_nxt_idx   = '0;
`ifdef DECODER_SCAN_EN
            w_nxt_pre   = '0;
`endif
        end
`ifdef DECODER_SCAN_EN
        else if (scan && (r_state != SCAN)) begin
            w_nxt_state = SCAN;
            w_nxt_idx   = '0;
            w_nxt_pre   = '0;
        end else if (r_state == SCAN) begin
            if (!scan) begin
                w_nxt_state = IDLE;
            end else if (r_pre == TC) begin
                w_nxt_pre = '0;
                w_nxt_idx = r_idx + N'(1);
            end else begin
                w_nxt_pre = r_pre + PW'(1);
            end
        end
`endif
        else if (w_accept) begin
            w_nxt_state = HOLD;
            w_nxt_idx   = a;
        end
    end

    // Outputs are decoded from next-state values so y, idx and y_valid move on the same edge.
    always_comb begin
        w_nxt_vld = (w_nxt_state != IDLE);
        w_nxt_y   = w_nxt_vld ? (W'(1) << w_nxt_idx) : '0;
        if (ACTIVE_LOW) begin
            w_nxt_y = ~w_nxt_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_y     <= {W{ACTIVE_LOW}};
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_y     <= w_nxt_y;
            r_vld   <= w_nxt_vld;
        end
    end

`ifdef DECODER_SCAN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else begin
            r_pre <= w_nxt_pre;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_nx2n_reg.sv
// Randomised + directed bench for decoder_nx2n_reg: two instances (N=3 active-high, N=2 active-low)
// checked every cycle against a behavioural model that derives scan position from elapsed cycles.
module tb_decoder_nx2n_reg;
`ifdef DECODER_SCAN_EN
    localparam bit SCAN_BUILD = 1'b1;
`else
    localparam bit SCAN_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] a_in;
    logic       a_valid;
    logic       scan;

    logic       a_ready0, y_valid0;
    logic [7:0] y0;
    logic [2:0] idx0;
    logic       a_ready1, y_valid1;
    logic [3:0] y1;
    logic [1:0] idx1;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int m_mode  [2];    // 0 idle, 1 hold, 2 scan
    int m_idx   [2];
    int m_start [2];

    always #5 clk = ~clk;

    decoder_nx2n_reg #(.N(3), .ACTIVE_LOW(1'b0), .SCAN_DIV(3)) dut0 (
        .clk(clk), .reset(reset), .en(en), .a(a_in), .a_valid(a_valid), .a_ready(a_ready0),
        .scan(scan), .y(y0), .y_valid(y_valid0), .idx(idx0));

    decoder_nx2n_reg #(.N(2), .ACTIVE_LOW(1'b1), .SCAN_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .a(a_in[1:0]), .a_valid(a_valid), .a_ready(a_ready1),
        .scan(scan), .y(y1), .y_valid(y_valid1), .idx(idx1));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit ready_exp(input int d);
        if (SCAN_BUILD) return en & ~scan & (m_mode[d] != 2);
        return en;
    endfunction

    function automatic logic [7:0] exp_y(input int d, input int n, input bit al);
        logic [7:0] v;
        v = (m_mode[d] == 0) ? 8'h00 : (8'h01 << m_idx[d]);
        if (al) v = ~v;
        return v & 8'((1 << (1 << n)) - 1);
    endfunction

    task automatic model_edge(input int d, input int n, input int div, input int av);
        bit rdy;
        rdy = ready_exp(d);
        if (!en) begin
            m_mode[d] = 0;
            m_idx[d]  = 0;
        end else if (SCAN_BUILD && scan && m_mode[d] != 2) begin
            m_mode[d]  = 2;
            m_idx[d]   = 0;
            m_start[d] = cyc;
        end else if (SCAN_BUILD && m_mode[d] == 2 && !scan) begin
            m_mode[d] = 0;
        end else if (m_mode[d] == 2) begin
            m_idx[d] = ((cyc - m_start[d]) / div) % (1 << n);
        end else if (av != 0 && rdy) begin
            m_mode[d] = 1;
            m_idx[d]  = int'(a_in) % (1 << n);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0;
            m_idx[d]  = 0;
        end
    endtask

    task automatic compare_outputs();
        chk("y0", y0, exp_y(0, 3, 1'b0));
        chk("y_valid0", y_valid0, m_mode[0] != 0);
        chk("idx0", idx0, m_idx[0]);
        chk("y1", y1, exp_y(1, 2, 1'b1));
        chk("y_valid1", y_valid1, m_mode[1] != 0);
        chk("idx1", idx1, m_idx[1]);
    endtask

    // One clock cycle: check combinational ready mid-cycle, advance model at the edge, compare after.
    task automatic step();
        int av;
        @(negedge clk);
        chk("a_ready0", a_ready0, ready_exp(0));
        chk("a_ready1", a_ready1, ready_exp(1));
        av = int'(a_valid);
        @(posedge clk);
        cyc++;
        model_edge(0, 3, 3, av);
        model_edge(1, 2, 1, av);
        #1;
        compare_outputs();
    endtask

    // Called just after an edge; reset must clear outputs well before the next edge.
    task automatic async_reset();
        reset = 1'b1;
        #2;
        model_reset();
        chk("rst_y0", y0, 8'h00);
        chk("rst_y1", y1, 4'hF);
        chk("rst_vld0", y_valid0, 1'b0);
        chk("rst_idx0", idx0, 3'd0);
        compare_outputs();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; a_in = '0; a_valid = 1'b0; scan = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y0", y0, 8'h00);
        chk("reset_y1", y1, 4'hF);
        chk("reset_vld1", y_valid1, 1'b0);
        compare_outputs();
        reset = 1'b0;
        step();

        en = 1'b1; a_in = 3'b010; a_valid = 1'b1;
        step();
        chk("load2_y0", y0, 8'h04);
        chk("load2_idx0", idx0, 3'd2);
        chk("load2_y1", y1, 4'b1011);
        a_valid = 1'b0;
        repeat (3) step();
        chk("hold_y0", y0, 8'h04);

        a_in = 3'd1; a_valid = 1'b1;
        step();
        chk("al_load1_y1", y1, 4'b1101);

        a_in = 3'd0; step();
        chk("b2b0_y0", y0, 8'h01);
        a_in = 3'd7; step();
        chk("b2b7_y0", y0, 8'h80);
        a_in = 3'd3; step();
        chk("b2b3_y0", y0, 8'h08);
        a_valid = 1'b0;

        en = 1'b0; step();
        chk("en0_y1", y1, 4'hF);
        chk("en0_vld1", y_valid1, 1'b0);
        en = 1'b1;

`ifdef DECODER_SCAN_EN
        scan = 1'b1; a_valid = 1'b1; a_in = 3'd5;
        step();
        chk("scan_entry_y0", y0, 8'h01);
        repeat (2) step();
        chk("scan_dwell_y0", y0, 8'h01);
        step();
        chk("scan_adv_y0", y0, 8'h02);
        repeat (3) step();
        chk("scan_mid_y0", y0, 8'h04);
        async_reset();
        step();
        chk("scan_restart_y0", y0, 8'h01);
        repeat (24) step();
        chk("scan_wrap_y0", y0, 8'h01);
        scan = 1'b0;
        step();
        chk("scan_exit_y0", y0, 8'h00);
        chk("scan_exit_vld0", y_valid0, 1'b0);
        a_valid = 1'b0;
`else
        scan = 1'b1; a_in = 3'd3; a_valid = 1'b1;
        step();
        chk("noscan_load_y0", y0, 8'h08);
        a_valid = 1'b0;
        repeat (20) step();
        chk("noscan_still_y0", y0, 8'h08);
        scan = 1'b0;
`endif

        for (int i = 0; i < 800; i++) begin
            en      = ($urandom_range(0, 19) != 0);
            a_valid = $urandom_range(0, 1);
            a_in    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) scan = ~scan;
            if ($urandom_range(0, 99) == 0) async_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
